// File: rtl/v_protect_pkg.sv
// v_protect_pkg: token kinds, sequencer states and error codes for the protect envelope sequencer
package v_protect_pkg;
  localparam int TOK_W = 3;
  typedef enum logic [TOK_W-1:0] {
    TK_BEGIN = 3'd0,
    TK_KEY   = 3'd1,
    TK_HDR   = 3'd2,
    TK_BYTE  = 3'd3,
    TK_END   = 3'd4,
    TK_RESET = 3'd5
  } tok_kind_e;
  typedef enum logic [2:0] {ST_IDLE, ST_OPEN, ST_KEY, ST_DATA, ST_CLOSE} state_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_UNEXP, ERR_SHORT, ERR_LONG} err_code_e;
endpackage

// File: rtl/v_protect_skid.sv
// v_protect_skid: one-entry valid/ready output register carrying a data word and a last flag
module v_protect_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  input  logic         in_last_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic         out_last_o
);
  logic         valid_q;
  logic [W-1:0] data_q;
  logic         last_q;
  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_last_o  = valid_q && last_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      if (in_valid_i) begin
        data_q <= in_data_i;
        last_q <= in_last_i;
      end
    end
  end
endmodule

// File: rtl/v_protect_seq.sv
// v_protect_seq: pragma protect envelope sequencer; define PROTECT_RESET_EN to accept RESET tokens in any state
module v_protect_seq
  import v_protect_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int DONE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tok_valid,
  output logic              tok_ready,
  input  logic [TOK_W-1:0]  tok_kind,
  input  logic [7:0]        tok_data,
  input  logic [CNT_W-1:0]  tok_count,
  output logic              key_strobe,
  output logic [7:0]        key_byte,
  output logic              dat_valid,
  input  logic              dat_ready,
  output logic [7:0]        dat_byte,
  output logic              dat_last,
  output logic              busy,
  output logic              err_pulse,
  output logic [1:0]        err_code,
  output logic [DONE_W-1:0] done_cnt
);
  state_e            state_q, state_d;
  err_code_e         err_q, err_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [DONE_W-1:0] done_q, done_d;
  logic              errp_q, errp_d;
  logic              ks_q, ks_d;
  logic [7:0]        kb_q, kb_d;
  logic              acc, rst_tok, push, push_last, flush, skid_ready;
`ifdef PROTECT_RESET_EN
  assign rst_tok = tok_kind == TK_RESET;
`else
  assign rst_tok = 1'b0;
`endif
  assign tok_ready  = (state_q == ST_DATA) ? skid_ready : 1'b1;
  assign acc        = tok_valid && tok_ready;
  assign busy       = state_q != ST_IDLE;
  assign err_pulse  = errp_q;
  assign err_code   = err_q;
  assign done_cnt   = done_q;
  assign key_strobe = ks_q;
  assign key_byte   = kb_q;
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    err_d     = err_q;
    done_d    = done_q;
    errp_d    = 1'b0;
    ks_d      = 1'b0;
    kb_d      = kb_q;
    push      = 1'b0;
    push_last = 1'b0;
    flush     = 1'b0;
    if (acc && rst_tok) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      flush   = 1'b1;
    end else if (acc) begin
      case (state_q)
        ST_IDLE: begin
          if (tok_kind == TK_BEGIN) begin
            state_d = ST_OPEN;
            err_d   = ERR_NONE;
          end else begin
            errp_d = 1'b1;
            err_d  = ERR_UNEXP;
          end
        end
        ST_OPEN, ST_KEY: begin
          if (tok_kind == TK_HDR) begin
            rem_d   = tok_count;
            state_d = (tok_count == '0) ? ST_CLOSE : ST_DATA;
          end else if (state_q == ST_OPEN && tok_kind == TK_KEY) begin
            state_d = ST_KEY;
          end else if (state_q == ST_KEY && tok_kind == TK_BYTE) begin
            ks_d = 1'b1;
            kb_d = tok_data;
          end else begin
            state_d = ST_IDLE;
            errp_d  = 1'b1;
            err_d   = ERR_UNEXP;
          end
        end
        ST_DATA: begin
          if (tok_kind == TK_BYTE) begin
            push      = 1'b1;
            push_last = rem_q == CNT_W'(1);
            rem_d     = rem_q - CNT_W'(1);
            state_d   = push_last ? ST_CLOSE : ST_DATA;
          end else begin
            // a disabled RESET is an unexpected token, not a short envelope
            state_d = ST_IDLE;
            rem_d   = '0;
            errp_d  = 1'b1;
            err_d   = (tok_kind == TK_RESET) ? ERR_UNEXP : ERR_SHORT;
          end
        end
        ST_CLOSE: begin
          if (tok_kind == TK_END) begin
            state_d = ST_IDLE;
            done_d  = done_q + DONE_W'(1);
          end else if (tok_kind == TK_BYTE) begin
            errp_d = 1'b1;
            err_d  = ERR_LONG;
          end else begin
            state_d = ST_IDLE;
            errp_d  = 1'b1;
            err_d   = ERR_UNEXP;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      err_q   <= ERR_NONE;
      rem_q   <= '0;
      done_q  <= '0;
      errp_q  <= 1'b0;
      ks_q    <= 1'b0;
      kb_q    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      errp_q  <= errp_d;
      ks_q    <= ks_d;
      kb_q    <= kb_d;
    end
  end
  v_protect_skid #(.W(8)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .in_valid_i (push),
    .in_data_i  (tok_data),
    .in_last_i  (push_last),
    .in_ready_o (skid_ready),
    .out_valid_o(dat_valid),
    .out_ready_i(dat_ready),
    .out_data_o (dat_byte),
    .out_last_o (dat_last)
  );
endmodule

// File: tb/tb_v_protect_seq.sv
// tb_v_protect_seq: scoreboard bench for the protect envelope sequencer
module tb_v_protect_seq;
  import v_protect_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        tok_valid;
  logic        tok_ready;
  logic [2:0]  tok_kind;
  logic [7:0]  tok_data;
  logic [15:0] tok_count;
  logic        key_strobe;
  logic [7:0]  key_byte;
  logic        dat_valid;
  logic        dat_ready;
  logic [7:0]  dat_byte;
  logic        dat_last;
  logic        busy;
  logic        err_pulse;
  logic [1:0]  err_code;
  logic [7:0]  done_cnt;
  int          vectors = 0;
  int          miscompares = 0;
  logic [8:0]  exp_dat[$];
  logic [7:0]  exp_key[$];
  logic [1:0]  exp_err[$];

  v_protect_seq dut (
    .clk(clk), .rst_n(rst_n), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_kind(tok_kind), .tok_data(tok_data), .tok_count(tok_count),
    .key_strobe(key_strobe), .key_byte(key_byte), .dat_valid(dat_valid),
    .dat_ready(dat_ready), .dat_byte(dat_byte), .dat_last(dat_last), .busy(busy),
    .err_pulse(err_pulse), .err_code(err_code), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic extra(input string n, input logic [31:0] a);
    vectors++;
    miscompares++;
    $display("FAIL %s unexpected output %0h", n, a);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (dat_valid && dat_ready) begin
        if (exp_dat.size() == 0) extra("dat", {dat_last, dat_byte});
        else chk("dat", {dat_last, dat_byte}, exp_dat.pop_front());
      end
      if (key_strobe) begin
        if (exp_key.size() == 0) extra("key", key_byte);
        else chk("key", key_byte, exp_key.pop_front());
      end
      if (err_pulse) begin
        if (exp_err.size() == 0) extra("err", err_code);
        else chk("err", err_code, exp_err.pop_front());
      end
    end
  end

  task automatic send(input logic [2:0] k, input logic [7:0] d = 8'h00, input logic [15:0] c = 16'h0);
    logic ok = 1'b0;
    tok_valid = 1'b1;
    tok_kind  = k;
    tok_data  = d;
    tok_count = c;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (tok_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
    if (!ok) extra("tok_accept_timeout", k);
  endtask

  task automatic dbyte(input logic [7:0] d, input logic l);
    exp_dat.push_back({l, d});
    send(TK_BYTE, d);
  endtask

  task automatic st(input string n, input logic b, input logic [1:0] e, input logic [7:0] dc);
    @(negedge clk);
    chk({n, "_busy"}, busy, b);
    chk({n, "_err"}, err_code, e);
    chk({n, "_done"}, done_cnt, dc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    tok_valid = 1'b0;
    tok_kind = 3'd0;
    tok_data = 8'h00;
    tok_count = 16'h0;
    dat_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_outs", {busy, dat_valid, dat_last, key_strobe, err_pulse, err_code, done_cnt}, 0);
    chk("rst_ready", tok_ready, 1'b1);
    @(posedge clk);
    #1;
    // well-formed envelope with a stall in the middle of the data
    send(TK_BEGIN);
    send(TK_KEY);
    exp_key.push_back(8'h11); send(TK_BYTE, 8'h11);
    exp_key.push_back(8'h22); send(TK_BYTE, 8'h22);
    exp_key.push_back(8'h33); send(TK_BYTE, 8'h33);
    send(TK_HDR, 8'h00, 16'd4);
    dbyte(8'hA1, 1'b0);
    dbyte(8'hA2, 1'b0);
    dat_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall", {dat_valid, tok_ready, dat_byte}, {2'b10, 8'hA2});
    end
    @(posedge clk);
    #1 dat_ready = 1'b1;
    dbyte(8'hA3, 1'b0);
    dbyte(8'hA4, 1'b1);
    send(TK_END);
    st("good", 1'b0, 2'd0, 8'd1);
    // short data
    send(TK_BEGIN);
    send(TK_HDR, 8'h00, 16'd4);
    dbyte(8'h05, 1'b0);
    dbyte(8'h06, 1'b0);
    exp_err.push_back(2'd2); send(TK_END);
    st("short", 1'b0, 2'd2, 8'd1);
    // long data: extra byte flagged and dropped, END still closes
    send(TK_BEGIN);
    send(TK_HDR, 8'h00, 16'd1);
    dbyte(8'h77, 1'b1);
    exp_err.push_back(2'd3); send(TK_BYTE, 8'h88);
    send(TK_END);
    st("long", 1'b0, 2'd3, 8'd2);
    // zero count
    send(TK_BEGIN);
    send(TK_HDR, 8'h00, 16'd0);
    st("zero_close", 1'b1, 2'd0, 8'd2);
    send(TK_END);
    st("zero", 1'b0, 2'd0, 8'd3);
    exp_err.push_back(2'd1); send(TK_BYTE, 8'h99);
    st("idle_byte", 1'b0, 2'd1, 8'd3);
    // RESET token mid-data
    send(TK_BEGIN);
    send(TK_HDR, 8'h00, 16'd3);
    dbyte(8'h09, 1'b0);
`ifdef PROTECT_RESET_EN
    send(TK_RESET);
    st("reset_tok", 1'b0, 2'd0, 8'd3);
`else
    exp_err.push_back(2'd1); send(TK_RESET);
    st("reset_tok", 1'b0, 2'd1, 8'd3);
`endif
    // illegal kind in OPEN, repeated KEY
    send(TK_BEGIN);
    exp_err.push_back(2'd1); send(3'd7);
    st("illegal", 1'b0, 2'd1, 8'd3);
    send(TK_BEGIN);
    send(TK_KEY);
    exp_err.push_back(2'd1); send(TK_KEY);
    st("key_key", 1'b0, 2'd1, 8'd3);
    // done counter wraps
    for (int i = 0; i < 253; i++) begin
      send(TK_BEGIN);
      send(TK_HDR, 8'h00, 16'd0);
      send(TK_END);
    end
    st("wrap", 1'b0, 2'd0, 8'd0);
    repeat (3) @(negedge clk);
    chk("dat_q_empty", exp_dat.size(), 0);
    chk("key_q_empty", exp_key.size(), 0);
    chk("err_q_empty", exp_err.size(), 0);
    @(posedge clk);
    #1;
    // async reset with a stalled byte pending
    send(TK_BEGIN);
    send(TK_HDR, 8'h00, 16'd2);
    dat_ready = 1'b0;
    send(TK_BYTE, 8'h42);
    @(negedge clk);
    chk("pend_valid", {dat_valid, dat_byte}, {1'b1, 8'h42});
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_outs", {busy, dat_valid, dat_last, err_code, done_cnt}, 0);
    rst_n = 1'b1;
    dat_ready = 1'b1;
    @(negedge clk);
    chk("arst_ready", {tok_ready, dat_valid}, 2'b10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
